// File: rtl/cp0_exception_unit_pkg.sv
// -----------------------------------------------------------------------------
// cp0_exception_unit_pkg
// Definitions shared by the commit-point exception unit and cp0_reg:
//   - excepttype codes driven into the CP0 register file
//   - CP0 register addresses used by mtc0 bypassing
//   - Status / Cause bit positions and MEM-stage exception flag positions
//   - FSM state encoding and the fixed-priority exception selector
// -----------------------------------------------------------------------------
package cp0_exception_unit_pkg;

    // excepttype codes understood by cp0_reg
    localparam logic [31:0] EXC_NONE     = 32'h0000_0000;
    localparam logic [31:0] EXC_INT      = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID  = 32'h0000_000a;
    localparam logic [31:0] EXC_OVERFLOW = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP     = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

    // CP0 register addresses
    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

    // Status fields
    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;

    // Cause fields writable by software (mtc0): IP[1:0], WP, IV
    localparam int CAUSE_WP_BIT = 22;
    localparam int CAUSE_IV_BIT = 23;

    // MEM-stage exception flag positions
    localparam int FLAG_SYSCALL_BIT  = 8;
    localparam int FLAG_INVALID_BIT  = 9;
    localparam int FLAG_TRAP_BIT     = 10;
    localparam int FLAG_OVERFLOW_BIT = 11;
    localparam int FLAG_ERET_BIT     = 12;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Fixed priority: interrupt > syscall > invalid > trap > overflow > eret.
    function automatic logic [31:0] select_exception(input logic        irq_pending,
                                                     input logic [31:0] flags);
        if (irq_pending)                   return EXC_INT;
        else if (flags[FLAG_SYSCALL_BIT])  return EXC_SYSCALL;
        else if (flags[FLAG_INVALID_BIT])  return EXC_INVALID;
        else if (flags[FLAG_TRAP_BIT])     return EXC_TRAP;
        else if (flags[FLAG_OVERFLOW_BIT]) return EXC_OVERFLOW;
        else if (flags[FLAG_ERET_BIT])     return EXC_ERET;
        else                               return EXC_NONE;
    endfunction

endpackage

// File: rtl/cp0_exception_unit_if.sv
// -----------------------------------------------------------------------------
// cp0_exception_unit_if
// Bundles the commit-slot, CP0 and WB-bypass inputs together with the
// exception decision outputs.
//   master : pipeline side; drives MEM/CP0/WB signals, receives the decision
//   slave  : exception unit; receives MEM/CP0/WB signals, drives the decision
// -----------------------------------------------------------------------------
interface cp0_exception_unit_if;

    // MEM commit slot
    logic        mem_valid_i;
    logic [31:0] mem_exc_flags_i;
    logic [31:0] mem_inst_addr_i;
    logic        mem_in_dslot_i;

    // Live CP0 registers
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;

    // mtc0 in WB, not yet visible in CP0
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;

    // Decision
    logic [31:0] excepttype_o;
    logic [31:0] cur_inst_addr_o;
    logic        in_dslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [31:0] exc_count_o;

    modport master (
        output mem_valid_i, mem_exc_flags_i, mem_inst_addr_i, mem_in_dslot_i,
        output cp0_status_i, cp0_cause_i, cp0_epc_i,
        output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        input  excepttype_o, cur_inst_addr_o, in_dslot_o, flush_o, new_pc_o, exc_count_o
    );

    modport slave (
        input  mem_valid_i, mem_exc_flags_i, mem_inst_addr_i, mem_in_dslot_i,
        input  cp0_status_i, cp0_cause_i, cp0_epc_i,
        input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        output excepttype_o, cur_inst_addr_o, in_dslot_o, flush_o, new_pc_o, exc_count_o
    );

endinterface

// File: rtl/cp0_exception_unit_bypass.sv
// -----------------------------------------------------------------------------
// cp0_bypass
// Combinational view of Status/Cause/EPC as they will be once the mtc0 now in
// WB lands, so a decision at commit never sees stale CP0 state.
//   cp0_status_i/cp0_cause_i/cp0_epc_i : registers as currently held
//   wb_we_i/wb_waddr_i/wb_data_i       : mtc0 in WB
//   status_o/cause_o/epc_o             : effective values
// -----------------------------------------------------------------------------
module cp0_bypass
    import cp0_exception_unit_pkg::*;
(
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o
);

    always_comb begin
        // NOTE: every output gets a default before the conditional overrides;
        // a path that leaves one unassigned would infer a latch.
        status_o = cp0_status_i;
        cause_o  = cp0_cause_i;
        epc_o    = cp0_epc_i;
        if (wb_we_i) begin
            case (wb_waddr_i)
                CP0_REG_STATUS: status_o = wb_data_i;
                CP0_REG_CAUSE: begin
                    // Only the software-writable Cause fields follow mtc0.
                    cause_o[9:8]          = wb_data_i[9:8];
                    cause_o[CAUSE_WP_BIT] = wb_data_i[CAUSE_WP_BIT];
                    cause_o[CAUSE_IV_BIT] = wb_data_i[CAUSE_IV_BIT];
                end
                CP0_REG_EPC:    epc_o = wb_data_i;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cp0_exception_unit.sv
// -----------------------------------------------------------------------------
// cp0_exception_unit
// Commit-point exception arbiter. Picks at most one exception per valid commit,
// hands excepttype/address/delay-slot to cp0_reg, flushes IF..MEM and supplies
// the redirect PC.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cp0_exception_unit_if.slave (MEM slot, CP0 values, WB bypass,
//              decision outputs)
// Parameters:
//   EXC_VECTOR   : redirect PC for every exception except eret
//   FLUSH_CYCLES : cycles flush_o is held, including the decision cycle (>=1)
// -----------------------------------------------------------------------------
module cp0_exception_unit
    import cp0_exception_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    cp0_exception_unit_if.slave   bus
);

    state_e      state_q, state_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [31:0] exc_count_q, exc_count_d;

    logic [31:0] eff_status, eff_cause, eff_epc;
    logic        irq_pending;
    logic [31:0] chosen_type;
    logic        take;
    logic [31:0] target_pc;

    logic [31:0] excepttype;
    logic [31:0] cur_inst_addr;
    logic        in_dslot;
    logic        flush;
    logic [31:0] new_pc;

    cp0_bypass u_bypass (
        .cp0_status_i (bus.cp0_status_i),
        .cp0_cause_i  (bus.cp0_cause_i),
        .cp0_epc_i    (bus.cp0_epc_i),
        .wb_we_i      (bus.wb_cp0_we_i),
        .wb_waddr_i   (bus.wb_cp0_waddr_i),
        .wb_data_i    (bus.wb_cp0_data_i),
        .status_o     (eff_status),
        .cause_o      (eff_cause),
        .epc_o        (eff_epc)
    );

    // Interrupts need IE=1, EXL=0 and an unmasked pending line.
    assign irq_pending = eff_status[STATUS_IE_BIT] & ~eff_status[STATUS_EXL_BIT]
                       & (|(eff_cause[15:8] & eff_status[15:8]));

    assign chosen_type = select_exception(irq_pending, bus.mem_exc_flags_i);
    assign target_pc   = (chosen_type == EXC_ERET) ? eff_epc : EXC_VECTOR;

    // Decisions only from IDLE: in FLUSH the MEM slot holds a squashed instruction.
    assign take = !rst && (state_q == ST_IDLE) && bus.mem_valid_i && (chosen_type != EXC_NONE);

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        new_pc_d      = new_pc_q;
        exc_count_d   = exc_count_q;
        excepttype    = EXC_NONE;
        cur_inst_addr = 32'h0;
        in_dslot      = 1'b0;
        flush         = 1'b0;
        new_pc        = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    excepttype    = chosen_type;
                    cur_inst_addr = bus.mem_inst_addr_i;
                    in_dslot      = bus.mem_in_dslot_i;
                    flush         = 1'b1;
                    new_pc        = target_pc;
                    new_pc_d      = target_pc;
                    exc_count_d   = exc_count_q + 32'd1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        // Counts remaining FLUSH cycles after this one, down to 0.
                        flush_cnt_d = 32'(FLUSH_CYCLES - 2);
                    end
                end
            end
            ST_FLUSH: begin
                flush  = 1'b1;
                new_pc = new_pc_q;
                if (flush_cnt_q == 32'h0) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples the
        // pre-edge _d values; the reset here is synchronous to match the core.
        if (rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= 32'h0;
            new_pc_q    <= 32'h0;
            exc_count_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            new_pc_q    <= new_pc_d;
            exc_count_q <= exc_count_d;
        end
    end

    assign bus.excepttype_o    = excepttype;
    assign bus.cur_inst_addr_o = cur_inst_addr;
    assign bus.in_dslot_o      = in_dslot;
    assign bus.flush_o         = flush;
    assign bus.new_pc_o        = new_pc;
    assign bus.exc_count_o     = exc_count_q;

    // Bits that play no part in the decision.
    logic unused_bits;
    assign unused_bits = ^{bus.mem_exc_flags_i[31:13], bus.mem_exc_flags_i[7:0],
                           eff_status[31:16], eff_status[7:2],
                           eff_cause[31:16], eff_cause[7:0]};

endmodule

// File: tb/tb_cp0_exception_unit.sv
// -----------------------------------------------------------------------------
// tb_cp0_exception_unit
// Directed bench for cp0_exception_unit with FLUSH_CYCLES=2, EXC_VECTOR=0x20.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit
// later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_cp0_exception_unit;

    logic clk = 1'b0;
    logic rst;

    cp0_exception_unit_if bus ();

    cp0_exception_unit #(
        .EXC_VECTOR   (32'h0000_0020),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] exp_count = 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.mem_valid_i     = 1'b0;
        bus.mem_exc_flags_i = 32'h0;
        bus.mem_inst_addr_i = 32'h0;
        bus.mem_in_dslot_i  = 1'b0;
        bus.cp0_status_i    = 32'h0;
        bus.cp0_cause_i     = 32'h0;
        bus.cp0_epc_i       = 32'h0;
        bus.wb_cp0_we_i     = 1'b0;
        bus.wb_cp0_waddr_i  = 5'd0;
        bus.wb_cp0_data_i   = 32'h0;
    endtask

    task automatic commit(input logic [31:0] flags, input logic [31:0] addr, input logic dslot);
        bus.mem_valid_i     = 1'b1;
        bus.mem_exc_flags_i = flags;
        bus.mem_inst_addr_i = addr;
        bus.mem_in_dslot_i  = dslot;
    endtask

    // Finish the FLUSH cycle and return to IDLE with quiet inputs.
    task automatic drain();
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        total_cnt++; if (bus.flush_o !== 1'b0) $display("FAIL reset_flush: got %b want 0", bus.flush_o); else pass_cnt++;
        total_cnt++; if (bus.excepttype_o !== 32'h0) $display("FAIL reset_type: got %h want 0", bus.excepttype_o); else pass_cnt++;
        total_cnt++; if (bus.new_pc_o !== 32'h0) $display("FAIL reset_new_pc: got %h want 0", bus.new_pc_o); else pass_cnt++;
        total_cnt++; if (bus.exc_count_o !== 32'h0) $display("FAIL reset_count: got %h want 0", bus.exc_count_o); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (bus.cur_inst_addr_o !== 32'h0 || bus.in_dslot_o !== 1'b0)
            $display("FAIL reset_addr_dslot: got %h/%b want 0/0", bus.cur_inst_addr_o, bus.in_dslot_o); else pass_cnt++;
    endtask

    task automatic test_syscall();
        commit(32'h0000_0100, 32'h0000_0400, 1'b0);
        #1;
        total_cnt++; if (bus.excepttype_o !== 32'h8) $display("FAIL syscall_type: got %h want 8", bus.excepttype_o); else pass_cnt++;
        total_cnt++; if (bus.cur_inst_addr_o !== 32'h400) $display("FAIL syscall_addr: got %h want 400", bus.cur_inst_addr_o); else pass_cnt++;
        total_cnt++; if (bus.in_dslot_o !== 1'b0) $display("FAIL syscall_dslot: got %b want 0", bus.in_dslot_o); else pass_cnt++;
        total_cnt++; if (bus.flush_o !== 1'b1) $display("FAIL syscall_flush1: got %b want 1", bus.flush_o); else pass_cnt++;
        total_cnt++; if (bus.new_pc_o !== 32'h20) $display("FAIL syscall_new_pc: got %h want 20", bus.new_pc_o); else pass_cnt++;
        exp_count++;
        tick();
        clear_inputs();
        #1;
        total_cnt++; if (bus.flush_o !== 1'b1) $display("FAIL syscall_flush2: got %b want 1", bus.flush_o); else pass_cnt++;
        total_cnt++; if (bus.new_pc_o !== 32'h20) $display("FAIL syscall_new_pc_held: got %h want 20", bus.new_pc_o); else pass_cnt++;
        total_cnt++; if (bus.exc_count_o !== 32'h1) $display("FAIL syscall_count: got %h want 1", bus.exc_count_o); else pass_cnt++;
        tick();
        total_cnt++; if (bus.flush_o !== 1'b0) $display("FAIL syscall_flush_end: got %b want 0", bus.flush_o); else pass_cnt++;
    endtask

    task automatic test_eret_bypass();
        commit(32'h0000_1000, 32'h0000_0440, 1'b0);
        bus.cp0_epc_i      = 32'h0;
        bus.wb_cp0_we_i    = 1'b1;
        bus.wb_cp0_waddr_i = 5'd14;
        bus.wb_cp0_data_i  = 32'h0000_1234;
        #1;
        total_cnt++; if (bus.excepttype_o !== 32'he) $display("FAIL eret_type: got %h want e", bus.excepttype_o); else pass_cnt++;
        total_cnt++; if (bus.new_pc_o !== 32'h1234) $display("FAIL eret_new_pc: got %h want 1234", bus.new_pc_o); else pass_cnt++;
        exp_count++;
        tick();
        clear_inputs();
        #1;
        total_cnt++; if (bus.new_pc_o !== 32'h1234) $display("FAIL eret_new_pc_held: got %h want 1234", bus.new_pc_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_interrupt_priority();
        // Interrupt beats overflow.
        commit(32'h0000_0800, 32'h0000_0600, 1'b0);
        bus.cp0_status_i = 32'h0000_0401;
        bus.cp0_cause_i  = 32'h0000_0400;
        #1;
        total_cnt++; if (bus.excepttype_o !== 32'h1) $display("FAIL irq_over_ovf: got %h want 1", bus.excepttype_o); else pass_cnt++;
        total_cnt++; if (bus.new_pc_o !== 32'h20) $display("FAIL irq_new_pc: got %h want 20", bus.new_pc_o); else pass_cnt++;
        exp_count++;
        drain();
        // EXL set masks the interrupt; overflow is taken.
        commit(32'h0000_0800, 32'h0000_0604, 1'b0);
        bus.cp0_status_i = 32'h0000_0403;
        bus.cp0_cause_i  = 32'h0000_0400;
        #1;
        total_cnt++; if (bus.excepttype_o !== 32'hc) $display("FAIL exl_masks_irq: got %h want c", bus.excepttype_o); else pass_cnt++;
        exp_count++;
        drain();
        // Status enabled only through the WB mtc0.
        commit(32'h0, 32'h0000_0608, 1'b0);
        bus.cp0_cause_i    = 32'h0000_0400;
        bus.wb_cp0_we_i    = 1'b1;
        bus.wb_cp0_waddr_i = 5'd12;
        bus.wb_cp0_data_i  = 32'h0000_0401;
        #1;
        total_cnt++; if (bus.excepttype_o !== 32'h1) $display("FAIL irq_status_bypass: got %h want 1", bus.excepttype_o); else pass_cnt++;
        exp_count++;
        drain();
        // Software interrupt line raised through the WB mtc0 to Cause.
        commit(32'h0, 32'h0000_060c, 1'b0);
        bus.cp0_status_i   = 32'h0000_0101;
        bus.wb_cp0_we_i    = 1'b1;
        bus.wb_cp0_waddr_i = 5'd13;
        bus.wb_cp0_data_i  = 32'h0000_0100;
        #1;
        total_cnt++; if (bus.excepttype_o !== 32'h1) $display("FAIL irq_cause_bypass: got %h want 1", bus.excepttype_o); else pass_cnt++;
        exp_count++;
        drain();
        // Cause[10] is hardware-owned: an mtc0 cannot raise it.
        commit(32'h0, 32'h0000_0610, 1'b0);
        bus.cp0_status_i   = 32'h0000_0401;
        bus.wb_cp0_we_i    = 1'b1;
        bus.wb_cp0_waddr_i = 5'd13;
        bus.wb_cp0_data_i  = 32'h0000_0400;
        #1;
        total_cnt++; if (bus.flush_o !== 1'b0 || bus.excepttype_o !== 32'h0)
            $display("FAIL cause_hw_bit_not_bypassed: got flush %b type %h want 0/0", bus.flush_o, bus.excepttype_o); else pass_cnt++;
        tick();
        clear_inputs();
        // invalid > trap > overflow > eret
        commit(32'h0000_1e00, 32'h0000_0614, 1'b0);
        #1;
        total_cnt++; if (bus.excepttype_o !== 32'ha) $display("FAIL prio_invalid: got %h want a", bus.excepttype_o); else pass_cnt++;
        exp_count++;
        drain();
        commit(32'h0000_1c00, 32'h0000_0618, 1'b0);
        #1;
        total_cnt++; if (bus.excepttype_o !== 32'hd) $display("FAIL prio_trap: got %h want d", bus.excepttype_o); else pass_cnt++;
        exp_count++;
        drain();
        total_cnt++; if (bus.exc_count_o !== exp_count) $display("FAIL irq_count: got %h want %h", bus.exc_count_o, exp_count); else pass_cnt++;
    endtask

    task automatic test_flush_ignore();
        commit(32'h0000_0100, 32'h0000_0700, 1'b0);
        #1;
        total_cnt++; if (bus.excepttype_o !== 32'h8) $display("FAIL fi_syscall_type: got %h want 8", bus.excepttype_o); else pass_cnt++;
        exp_count++;
        tick();
        commit(32'h0000_0800, 32'h0000_0704, 1'b1);
        #1;
        total_cnt++; if (bus.excepttype_o !== 32'h0) $display("FAIL fi_type_in_flush: got %h want 0", bus.excepttype_o); else pass_cnt++;
        total_cnt++; if (bus.cur_inst_addr_o !== 32'h0) $display("FAIL fi_addr_in_flush: got %h want 0", bus.cur_inst_addr_o); else pass_cnt++;
        total_cnt++; if (bus.flush_o !== 1'b1) $display("FAIL fi_flush_held: got %b want 1", bus.flush_o); else pass_cnt++;
        tick();
        clear_inputs();
        #1;
        total_cnt++; if (bus.exc_count_o !== exp_count) $display("FAIL fi_count: got %h want %h", bus.exc_count_o, exp_count); else pass_cnt++;
        total_cnt++; if (bus.flush_o !== 1'b0) $display("FAIL fi_flush_end: got %b want 0", bus.flush_o); else pass_cnt++;
    endtask

    task automatic test_bubble();
        bus.mem_valid_i  = 1'b0;
        bus.cp0_status_i = 32'h0000_0401;
        bus.cp0_cause_i  = 32'h0000_0400;
        #1;
        total_cnt++; if (bus.flush_o !== 1'b0) $display("FAIL bubble_flush: got %b want 0", bus.flush_o); else pass_cnt++;
        tick();
        total_cnt++; if (bus.exc_count_o !== exp_count) $display("FAIL bubble_count: got %h want %h", bus.exc_count_o, exp_count); else pass_cnt++;
        commit(32'h0, 32'h0000_0500, 1'b1);
        #1;
        total_cnt++; if (bus.excepttype_o !== 32'h1) $display("FAIL bubble_irq_type: got %h want 1", bus.excepttype_o); else pass_cnt++;
        total_cnt++; if (bus.in_dslot_o !== 1'b1) $display("FAIL bubble_dslot: got %b want 1", bus.in_dslot_o); else pass_cnt++;
        total_cnt++; if (bus.cur_inst_addr_o !== 32'h500) $display("FAIL bubble_addr: got %h want 500", bus.cur_inst_addr_o); else pass_cnt++;
        exp_count++;
        drain();
    endtask

    task automatic test_reset_mid_flush();
        commit(32'h0000_0100, 32'h0000_0900, 1'b0);
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        total_cnt++; if (bus.flush_o !== 1'b0) $display("FAIL rmf_flush: got %b want 0", bus.flush_o); else pass_cnt++;
        total_cnt++; if (bus.new_pc_o !== 32'h0) $display("FAIL rmf_new_pc: got %h want 0", bus.new_pc_o); else pass_cnt++;
        total_cnt++; if (bus.exc_count_o !== 32'h0) $display("FAIL rmf_count: got %h want 0", bus.exc_count_o); else pass_cnt++;
        rst = 1'b0;
        exp_count = 32'h0;
        // Back in IDLE: a fresh commit is taken at once.
        commit(32'h0000_0100, 32'h0000_0910, 1'b0);
        #1;
        total_cnt++; if (bus.excepttype_o !== 32'h8 || bus.flush_o !== 1'b1)
            $display("FAIL rmf_idle_take: got type %h flush %b want 8/1", bus.excepttype_o, bus.flush_o); else pass_cnt++;
        exp_count++;
        drain();
    endtask

    task automatic test_back_to_back();
        commit(32'h0000_0100, 32'h0000_0a00, 1'b0);
        exp_count++;
        tick();
        clear_inputs();
        tick();
        commit(32'h0000_0800, 32'h0000_0a04, 1'b0);
        #1;
        total_cnt++; if (bus.excepttype_o !== 32'hc) $display("FAIL b2b_type: got %h want c", bus.excepttype_o); else pass_cnt++;
        total_cnt++; if (bus.cur_inst_addr_o !== 32'ha04) $display("FAIL b2b_addr: got %h want a04", bus.cur_inst_addr_o); else pass_cnt++;
        exp_count++;
        drain();
        total_cnt++; if (bus.exc_count_o !== exp_count) $display("FAIL b2b_count: got %h want %h", bus.exc_count_o, exp_count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_eret_bypass();
        test_interrupt_priority();
        test_flush_ignore();
        test_bubble();
        test_reset_mid_flush();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
